mmss_display_scheduler: RTL and testbench

- Converts a binary minutes/seconds pair (0-59 each) into four BCD digits using one shared iterative divide-by-10 unit.
- Processes minutes first, then seconds, and commits both atomically.
- Time-multiplexes the four digits onto an active-low 4-digit seven-segment display.
- Sits between the stopwatch/clock counters and the board display pins.

---
 rtl/mmss_display_scheduler_pkg.sv | 26 ++
 rtl/mmss_display_scheduler_seg7_decoder.sv | 29 ++
 rtl/mmss_display_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mmss_display_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmss_display_scheduler_pkg.sv
// Shared types and constants for the mm:ss display scheduler.
package mmss_disp_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_M = 2'd1,
    CONV_S = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Which of the four display positions is currently lit.
  typedef logic [1:0] digit_idx_t;

  // Active-low digit enables, indexed by digit position (0 = seconds ones).
  localparam logic [3:0] AN_CODE [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Saturate a captured 6-bit value at the configured ceiling.
  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] ceil);
    return (v > ceil) ? ceil : v;
  endfunction

endpackage

// File: rtl/mmss_display_scheduler_seg7_decoder.sv
// BCD to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
// Non-decimal codes 10-15 light nothing.
module seg7_decoder
  import mmss_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; every input code has an explicit result.
  always_comb begin
    // NOTE: a default assignment before the case guarantees no latch is inferred.
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mmss_display_scheduler.sv
// Binary mm:ss to BCD converter with a shared repeated-subtraction divider,
// atomic commit of all four digits, and a 4-digit multiplexed display scan.
// Optional macro MMSS_BLANK_LEAD_EN blanks the minutes-tens digit when it is 0.
module mmss_display_scheduler
  import mmss_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int MAX_VAL  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int               CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [5:0]       CEIL    = 6'(MAX_VAL);

  state_t     state, state_n;
  logic [5:0] r;
  logic [2:0] q;
  logic [5:0] cap_s;
  logic       pend;
  logic [5:0] pend_m, pend_s;
  logic [3:0] sh_m10, sh_m1, sh_s10, sh_s1;
  logic [3:0] disp_m10, disp_m1, disp_s10, disp_s1;

  logic [CNT_W-1:0] scan_cnt;
  digit_idx_t       idx, idx_n;
  logic [3:0]       scan_digit;
  logic [6:0]       dec_seg, seg_n;

  logic r_ge_10;
  assign r_ge_10 = (r >= 6'd10);
  assign busy    = (state != IDLE);

  // Next-state selection and the one-cycle done strobe.
  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:   if (load) state_n = CONV_M;
      CONV_M: if (!r_ge_10) state_n = CONV_S;
      CONV_S: if (!r_ge_10) state_n = COMMIT;
      COMMIT: begin
        done    = 1'b1;
        // A request arriving in this very cycle chains just like a pending one.
        state_n = (pend || load) ? CONV_M : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, divider datapath, pending request and digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      r        <= '0;
      q        <= '0;
      cap_s    <= '0;
      pend     <= 1'b0;
      pend_m   <= '0;
      pend_s   <= '0;
      sh_m10   <= '0;
      sh_m1    <= '0;
      sh_s10   <= '0;
      sh_s1    <= '0;
      disp_m10 <= '0;
      disp_m1  <= '0;
      disp_s10 <= '0;
      disp_s1  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_n;
      case (state)
        IDLE: begin
          if (load) begin
            r     <= clamp6(mins, CEIL);
            q     <= '0;
            cap_s <= clamp6(secs, CEIL);
          end
        end
        CONV_M: begin
          if (r_ge_10) begin
            r <= r - 6'd10;
            q <= q + 3'd1;
          end else begin
            sh_m10 <= {1'b0, q};
            sh_m1  <= r[3:0];
            r      <= cap_s;
            q      <= '0;
          end
        end
        CONV_S: begin
          if (r_ge_10) begin
            r <= r - 6'd10;
            q <= q + 3'd1;
          end else begin
            sh_s10 <= {1'b0, q};
            sh_s1  <= r[3:0];
          end
        end
        COMMIT: begin
          disp_m10 <= sh_m10;
          disp_m1  <= sh_m1;
          disp_s10 <= sh_s10;
          disp_s1  <= sh_s1;
          pend     <= 1'b0;
          q        <= '0;
          if (load) begin
            r     <= clamp6(mins, CEIL);
            cap_s <= clamp6(secs, CEIL);
          end else if (pend) begin
            r     <= pend_m;
            cap_s <= pend_s;
          end
        end
        default: ;
      endcase
      // Requests during conversion park in the one-deep pending slot; last one wins.
      if (load && (state == CONV_M || state == CONV_S)) begin
        pend   <= 1'b1;
        pend_m <= clamp6(mins, CEIL);
        pend_s <= clamp6(secs, CEIL);
      end
    end
  end

  // Index the display will show after this edge, and that position's digit.
  always_comb begin
    idx_n = (scan_cnt == CNT_MAX) ? idx + 2'd1 : idx;
    case (idx_n)
      2'd0:    scan_digit = disp_s1;
      2'd1:    scan_digit = disp_s10;
      2'd2:    scan_digit = disp_m1;
      default: scan_digit = disp_m10;
    endcase
  end

  seg7_decoder u_dec (
    .bcd (scan_digit),
    .seg (dec_seg)
  );

  // Leading-zero blanking on the minutes-tens position when enabled.
  always_comb begin
    seg_n = dec_seg;
`ifdef MMSS_BLANK_LEAD_EN
    if (idx_n == 2'd3 && disp_m10 == 4'd0) seg_n = SEG_BLANK;
`endif
  end

  // Scan divider and registered display pins, refreshed every edge from idx_n.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= AN_CODE[0];
      seg      <= SEG_ZERO;
      dp       <= 1'b1;
    end else begin
      scan_cnt <= (scan_cnt == CNT_MAX) ? '0 : scan_cnt + 1'b1;
      idx      <= idx_n;
      an       <= AN_CODE[idx_n];
      seg      <= seg_n;
      dp       <= (idx_n != 2'd2);
    end
  end

endmodule

// File: tb/tb_mmss_display_scheduler.sv
// Self-checking bench for mmss_display_scheduler (SCAN_DIV=4).
module tb_mmss_display_scheduler;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [5:0] mins, secs;
  logic       busy, done;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  mmss_display_scheduler #(.SCAN_DIV(SCAN_DIV), .MAX_VAL(59)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .mins (mins),
    .secs (secs),
    .busy (busy),
    .done (done),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] an_of(input int pos);
    case (pos)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int clampv(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  // One request from idle: checks busy, exact done timing, and single pulse.
  task automatic do_conv(input int m, input int s);
    int cm, cs, lat;
    bit early;
    cm = clampv(m);
    cs = clampv(s);
    lat = cm / 10 + cs / 10 + 2;
    early = 1'b0;
    mins = 6'(m);
    secs = 6'(s);
    load = 1'b1;
    step();
    load = 1'b0;
    check("busy_after_load", 32'(busy), 32'd1);
    for (int k = 0; k < lat; k++) begin
      if (done) early = 1'b1;
      step();
    end
    check("done_not_early", 32'(early), 32'd0);
    check("done_at_latency", 32'(done), 32'd1);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Walk the scan and compare each lit position with the expected mm:ss.
  task automatic check_display(input int m, input int s);
    int cm, cs;
    int dig [4];
    logic [6:0] exp_seg;
    bit found;
    cm = clampv(m);
    cs = clampv(s);
    dig[0] = cs % 10;
    dig[1] = cs / 10;
    dig[2] = cm % 10;
    dig[3] = cm / 10;
    step();
    for (int j = 0; j < 4; j++) begin
      found = 1'b0;
      for (int w = 0; w < 4 * SCAN_DIV + 2 && !found; w++) begin
        if (an === an_of(j)) found = 1'b1;
        else step();
      end
      check("scan_reaches_digit", 32'(found), 32'd1);
      exp_seg = seg_of(dig[j]);
`ifdef MMSS_BLANK_LEAD_EN
      if (j == 3 && dig[3] == 0) exp_seg = 7'b1111111;
`endif
      check($sformatf("seg_pos%0d_%0d_%0d", j, cm, cs), 32'(seg), 32'(exp_seg));
      check("dp_pos", 32'(dp), (j == 2) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    int pulses;
    rst  = 1'b1;
    load = 1'b0;
    mins = '0;
    secs = '0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_an", 32'(an), 32'hE);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_dp", 32'(dp), 32'd1);

    // Scan pattern straight out of reset.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("scan_an", 32'(an), 32'(an_of(i / 4)));
      check("scan_seg", 32'(seg), 32'h40);
      check("scan_dp", 32'(dp), (i / 4 == 2) ? 32'd0 : 32'd1);
      step();
    end

    // Worst-case latency.
    do_conv(59, 59);
    check_display(59, 59);

    // Shortest conversion replacing a full display.
    do_conv(12, 34);
    check_display(12, 34);
    do_conv(0, 0);
    check_display(0, 0);

    // Clamping.
    do_conv(63, 60);
    check_display(63, 60);

    // Pending: only the last request made while busy survives.
    mins = 6'd7; secs = 6'd3; load = 1'b1;
    step();
    mins = 6'd44; secs = 6'd21;
    step();
    mins = 6'd10; secs = 6'd10;
    step();
    load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      step();
    end
    check("pending_two_pulses", 32'(pulses), 32'd2);
    check("pending_idle", 32'(busy), 32'd0);
    check_display(10, 10);

    // Reset in the middle of the seconds conversion, with a request parked.
    mins = 6'd30; secs = 6'd40; load = 1'b1;
    step();
    mins = 6'd22; secs = 6'd22;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("midconv_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_an", 32'(an), 32'hE);
    check("abort_seg", 32'(seg), 32'h40);
    check("abort_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) pulses++;
      step();
    end
    check("abort_no_activity", 32'(pulses), 32'd0);
    check_display(0, 0);

    // Leading-zero case.
    do_conv(5, 7);
    check_display(5, 7);

    // Randomized requests against the arithmetic model.
    for (int n = 0; n < 12; n++) begin
      int rm, rs;
      rm = int'($urandom_range(0, 63));
      rs = int'($urandom_range(0, 63));
      do_conv(rm, rs);
      check_display(rm, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
